// File: rtl/ps2_keyboard_rx_if.sv
// CPU-side register interface of the PS/2 keyboard receiver: read/clear
// strobes from the CPU and head byte plus status flags back to it.
interface ps2_keyboard_rx_if;
   logic       kb_rd;
   logic       kb_clr;
   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_overflow;
   logic       kb_frame_err;

   modport master (
      output kb_rd, kb_clr,
      input  kb_data, kb_ready, kb_overflow, kb_frame_err
   );

   modport slave (
      input  kb_rd, kb_clr,
      output kb_data, kb_ready, kb_overflow, kb_frame_err
   );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: line conditioning, 11-bit frame FSM with
// parity/stop checking and timeout abort, and a first-word-fall-through byte FIFO.
module ps2_keyboard_rx #(
   parameter int FILTER     = 8,
   parameter int TIMEOUT    = 12500,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             ps2_dat,
   ps2_keyboard_rx_if.slave bus
);

   localparam int FW    = (FILTER > 1) ? $clog2(FILTER) : 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic          clk_sync_p0, clk_sync_p1;
   logic          dat_sync_p0, dat_sync_p1;
   logic          clk_filt;
   logic [FW-1:0] filt_cnt;
   logic          fall_p2;

   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic          ok_q, ok_d;
   logic [TW-1:0] to_cnt_q;
   logic          timeout_hit;
   logic          push, ferr_set;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  pop, full, push_ok, ovf_set;

   // ---- stage p0/p1: two-flop synchronisers ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_sync_p0 <= 1'b1;
         clk_sync_p1 <= 1'b1;
         dat_sync_p0 <= 1'b1;
         dat_sync_p1 <= 1'b1;
      end else begin
         clk_sync_p0 <= ps2_clk;
         clk_sync_p1 <= clk_sync_p0;
         dat_sync_p0 <= ps2_dat;
         dat_sync_p1 <= dat_sync_p0;
      end
   end

   // ---- stage p2: glitch filter; fall_p2 is high in the first cycle the filtered clock reads 0 ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         fall_p2  <= 1'b0;
      end else begin
         fall_p2 <= 1'b0;
         if (clk_sync_p1 != clk_filt) begin
            if (filt_cnt == FILT_MAX) begin
               clk_filt <= clk_sync_p1;
               filt_cnt <= '0;
               fall_p2  <= clk_filt;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   assign timeout_hit = (state_q != IDLE) && !fall_p2 && (to_cnt_q == TO_MAX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bitcnt_q <= '0;
         ok_q     <= 1'b0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         ok_q     <= ok_d;
         if (state_q == IDLE || fall_p2)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      ok_d     = ok_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      if (fall_p2) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_sync_p1) begin
                  state_d  = DATA;
                  bitcnt_d = '0;
               end else begin
                  ferr_set = 1'b1;
               end
            end
            DATA: begin
               shift_d  = {dat_sync_p1, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               ok_d    = odd_parity_ok(shift_q, dat_sync_p1);
               state_d = STOP;
            end
            STOP: begin
               if (dat_sync_p1 && ok_q) push = 1'b1;
               else                     ferr_set = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (timeout_hit) begin
         state_d  = IDLE;
         ferr_set = 1'b1;
      end
   end

   // ---- FIFO: a pop in the same cycle frees the slot for a push into a full FIFO ----
   assign pop     = bus.kb_rd && (count_q != '0);
   assign full    = (count_q == CNT_FULL);
   assign push_ok = push && (!full || pop);
   assign ovf_set = push && full && !pop;

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= shift_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.kb_overflow  <= 1'b0;
         bus.kb_frame_err <= 1'b0;
      end else begin
         if (ovf_set)         bus.kb_overflow <= 1'b1;
         else if (bus.kb_clr) bus.kb_overflow <= 1'b0;
         if (ferr_set)        bus.kb_frame_err <= 1'b1;
         else if (bus.kb_clr) bus.kb_frame_err <= 1'b0;
      end
   end

   assign bus.kb_ready = (count_q != '0);
   assign bus.kb_data  = (count_q != '0) ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: frame-level reference model (byte queue
// plus sticky flags) compared every cycle, plus literal spot checks.
module tb_ps2_keyboard_rx;
   localparam int FILTER  = 8;
   localparam int TIMEOUT = 12500;
   localparam int DEPTH   = 8;
   localparam int FAST    = 40;
   localparam int SLOW    = 1040;

   logic clock   = 1'b0;
   logic reset   = 1'b1;
   logic ps2_clk = 1'b1;
   logic ps2_dat = 1'b1;

   ps2_keyboard_rx_if bus ();

   ps2_keyboard_rx #(
      .FILTER    (FILTER),
      .TIMEOUT   (TIMEOUT),
      .DEPTH_LOG2(3)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .ps2_clk(ps2_clk),
      .ps2_dat(ps2_dat),
      .bus    (bus)
   );

   always #20 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   bit m_ovf  = 1'b0;
   bit m_ferr = 1'b0;
   bit hold   = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state is only unsettled while a frame result is in flight.
   always @(negedge clock) begin
      if (!hold) begin
         check("cmp_ready", bus.kb_ready, (mq.size() != 0));
         check("cmp_data", bus.kb_data, (mq.size() != 0) ? mq[0] : 8'h00);
         check("cmp_ovf", bus.kb_overflow, m_ovf);
         check("cmp_ferr", bus.kb_frame_err, m_ferr);
      end
   end

   task automatic model_push(input logic [7:0] b, input bit with_pop);
      if (mq.size() == DEPTH && !with_pop) begin
         m_ovf = 1'b1;
      end else begin
         if (with_pop && mq.size() != 0) void'(mq.pop_front());
         mq.push_back(b);
      end
   endtask

   task automatic ps2_bit(input bit b, input int half);
      @(posedge clock); #1 ps2_dat = b;
      repeat (half) @(posedge clock);
      #1 ps2_clk = 1'b0;
      repeat (half) @(posedge clock);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_push,
                             input int half);
      ps2_bit(1'b0, half);
      for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
      ps2_bit((~^b) ^ bad_par, half);
      @(posedge clock); #1 ps2_dat = 1'b1;
      repeat (half) @(posedge clock);
      #1 ps2_clk = 1'b0;
      hold = 1'b1;
      repeat (FILTER + 2) @(posedge clock);
      #1 if (pop_at_push) bus.kb_rd = 1'b1;
      @(posedge clock);
      #1 bus.kb_rd = 1'b0;
      if (bad_par) m_ferr = 1'b1;
      else         model_push(b, pop_at_push);
      hold = 1'b0;
      repeat (half - FILTER - 3) @(posedge clock);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits, input int half);
      ps2_bit(1'b0, half);
      for (int i = 0; i < nbits; i++) ps2_bit(b[i], half);
   endtask

   task automatic do_rd();
      @(posedge clock); #1 bus.kb_rd = 1'b1;
      @(posedge clock); #1 bus.kb_rd = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic do_clr();
      @(posedge clock); #1 bus.kb_clr = 1'b1;
      @(posedge clock); #1 bus.kb_clr = 1'b0;
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      check({name, "_ready"}, bus.kb_ready, 1);
      check(name, bus.kb_data, exp);
      do_rd();
   endtask

   initial begin
      bus.kb_rd  = 1'b0;
      bus.kb_clr = 1'b0;
      reset      = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", bus.kb_ready, 0);
      check("rst_data", bus.kb_data, 8'h00);
      check("rst_ovf", bus.kb_overflow, 0);
      check("rst_ferr", bus.kb_frame_err, 0);
      reset = 1'b0;
      hold  = 1'b0;

      // baseline 0x1C at ~12 kHz
      send_frame(8'h1C, 1'b0, 1'b0, SLOW);
      check("base_ready", bus.kb_ready, 1);
      check("base_data", bus.kb_data, 8'h1C);
      check("base_ferr", bus.kb_frame_err, 0);
      check("base_ovf", bus.kb_overflow, 0);
      do_rd();
      check("base_empty", bus.kb_ready, 0);

      // parity error
      send_frame(8'h1C, 1'b1, 1'b0, FAST);
      check("par_ready", bus.kb_ready, 0);
      check("par_ferr", bus.kb_frame_err, 1);
      do_clr();
      check("par_clr", bus.kb_frame_err, 0);

      // overflow: nine pushes, no reads
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, FAST);
      check("ovf_set", bus.kb_overflow, 1);
      for (int i = 1; i <= 8; i++) pop_expect("ovf_pop", 8'(i));
      check("ovf_drained", bus.kb_ready, 0);
      do_clr();

      // ninth push coincides with a read
      for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, FAST);
      send_frame(8'h09, 1'b0, 1'b1, FAST);
      check("pp_no_ovf", bus.kb_overflow, 0);
      for (int i = 2; i <= 9; i++) pop_expect("pp_pop", 8'(i));
      check("pp_drained", bus.kb_ready, 0);

      // short glitch on the clock line
      @(posedge clock); #1 ps2_clk = 1'b0;
      repeat (3) @(posedge clock);
      #1 ps2_clk = 1'b1;
      repeat (30) @(posedge clock);
      #1;
      check("glitch_ferr", bus.kb_frame_err, 0);
      check("glitch_ready", bus.kb_ready, 0);

      // timeout after five data bits
      send_partial(8'hA5, 5, FAST);
      repeat (TIMEOUT - 100) @(posedge clock);
      #1 check("to_early", bus.kb_frame_err, 0);
      hold = 1'b1;
      repeat (300) @(posedge clock);
      #1 m_ferr = 1'b1;
      hold = 1'b0;
      check("to_ferr", bus.kb_frame_err, 1);
      do_clr();
      send_frame(8'hF0, 1'b0, 1'b0, FAST);
      check("to_next_data", bus.kb_data, 8'hF0);
      check("to_next_ferr", bus.kb_frame_err, 0);

      // asynchronous reset mid-frame with bytes buffered
      send_frame(8'h11, 1'b0, 1'b0, FAST);
      send_frame(8'h22, 1'b0, 1'b0, FAST);
      send_partial(8'h33, 4, FAST);
      @(negedge clock);
      #3 reset = 1'b1;
      mq.delete();
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
      #1;
      check("mrst_ready", bus.kb_ready, 0);
      check("mrst_data", bus.kb_data, 8'h00);
      check("mrst_ovf", bus.kb_overflow, 0);
      check("mrst_ferr", bus.kb_frame_err, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b0, FAST);
      check("post_rst_data", bus.kb_data, 8'h5A);
      check("post_rst_ready", bus.kb_ready, 1);
      do_rd();
      check("post_rst_empty", bus.kb_ready, 0);

      repeat (5) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
